router_reg: RTL

- Datapath register stage of the 1x3 router. Sits between the input port and the per-destination router_fifo instances.
- Latches the header byte and forwards header, payload and parity bytes on dout to the FIFO write port. It is sequenced by the router FSM state strobes.
- Holds one byte when the selected FIFO is full.
- Accumulates running XOR parity, compares it with the received parity byte, and flags err.

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_parity_chk.sv | 105 ++++++++++
 rtl/router_reg.sv | 107 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and FSM state encoding for the 1x3 router datapath and controller.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  // Header layout: payload length in the upper bits, destination in the lower bits.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_e;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, capture of the received parity byte,
// and the per-packet mismatch flag.
module router_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] header_byte,
  input  logic [DATA_WIDTH-1:0] hold_byte,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  low_pkt_valid,
  output logic                  parity_done,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  parity_done_q, parity_done_d;
  logic                  parity_done_dly_q, parity_done_dly_d;
  logic                  err_q, err_d;
  logic                  cap_direct_s, cap_held_s;

  function automatic logic [DATA_WIDTH-1:0] parity_accum(input logic [DATA_WIDTH-1:0] acc,
                                                         input logic [DATA_WIDTH-1:0] b);
    return acc ^ b;
  endfunction

  // Next-state for parity accumulator, parity capture, done flag and error flag.
  always_comb begin
    int_parity_d      = int_parity_q;
    pkt_parity_d      = pkt_parity_q;
    parity_done_d     = parity_done_q;
    parity_done_dly_d = parity_done_q;
    err_d             = err_q;

    // Parity byte arrives either straight from the source or, after a full stall, from hold_byte.
    cap_direct_s = ld_state && !pkt_valid && !fifo_full;
    cap_held_s   = laf_state && low_pkt_valid && !parity_done_q;

    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = parity_accum(int_parity_q, header_byte);
    end else if (ld_state && pkt_valid && !full_state) begin
      int_parity_d = parity_accum(int_parity_q, data_in);
    end else begin
      int_parity_d = int_parity_q;
    end

    if (cap_direct_s) begin
      pkt_parity_d = data_in;
    end else if (cap_held_s) begin
      pkt_parity_d = hold_byte;
    end else begin
      pkt_parity_d = pkt_parity_q;
    end

    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (cap_direct_s || cap_held_s) begin
      parity_done_d = 1'b1;
    end else begin
      parity_done_d = parity_done_q;
    end

    // Compare one cycle after capture so pkt_parity is already registered.
    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q && !parity_done_dly_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end else begin
      err_d = err_q;
    end
  end

  // Parity state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_parity_q      <= '0;
      pkt_parity_q      <= '0;
      parity_done_q     <= 1'b0;
      parity_done_dly_q <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      int_parity_q      <= int_parity_d;
      pkt_parity_q      <= pkt_parity_d;
      parity_done_q     <= parity_done_d;
      parity_done_dly_q <= parity_done_dly_d;
      err_q             <= err_d;
    end
  end

  assign parity_done = parity_done_q;
  assign err         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, byte forwarding to the FIFO write port,
// stall holding when the FIFO is full, and parity checking.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  addr_ok_s;

  // Next-state for header latch, stall buffer, forwarded byte and low_pkt_valid.
  always_comb begin
    header_d        = header_q;
    hold_d          = hold_q;
    dout_d          = dout_q;
    low_pkt_valid_d = low_pkt_valid_q;

    addr_ok_s = (data_in[HDR_ADDR_LSB +: ADDR_WIDTH] != ADDR_WIDTH'(INVALID_ADDR));

    if (detect_add && pkt_valid && addr_ok_s) begin
      header_d = data_in;
    end else begin
      header_d = header_q;
    end

    // When the FIFO is full the byte is parked in hold_byte and replayed in LOAD_AFTER_FULL.
    if (lfd_state) begin
      dout_d = header_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (ld_state) begin
      hold_d = data_in;
    end else if (laf_state) begin
      dout_d = hold_q;
    end else begin
      dout_d = dout_q;
    end

    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else begin
      low_pkt_valid_d = low_pkt_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header_q        <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_chk (
    .clk           (clk),
    .resetn        (resetn),
    .data_in       (data_in),
    .header_byte   (header_q),
    .hold_byte     (hold_q),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .low_pkt_valid (low_pkt_valid_q),
    .parity_done   (parity_done),
    .err           (err)
  );

  assign dout          = dout_q;
  assign low_pkt_valid = low_pkt_valid_q;

endmodule
